// File: rtl/fp_block_accum.sv
// fp_block_accum: expands 8-bit float codes (s|eee|vvvv, value = (-1)^s * v * 2^e)
// back to signed integers and accumulates blocks of 2^N_LOG2 samples with
// saturation. Each completed block result is held on a registered valid/ready
// output until the next stage accepts it.
//
// Optional feature macro: FP_BLOCK_ACCUM_MEAN_EN
//   defined   -> out_sum carries the rounded block mean, (sum + 2^(N_LOG2-1)) >>> N_LOG2
//   undefined -> out_sum carries the saturated block sum
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush of partial block and pending output
//   in_valid   in_fp valid
//   in_ready   block can accept in_fp (ACCUM state)
//   in_fp      float code [7] sign, [6:4] exponent, [3:0] significand
//   out_valid  out_sum/out_ovf hold a completed block (HOLD state)
//   out_ready  downstream accepts the result
//   out_sum    signed block sum (or mean), ACC_W bits
//   out_ovf    saturation occurred at least once during the block

module fp_block_accum #(
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned N_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_fp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned MAG_W = 11;
    localparam int unsigned CNT_W = N_LOG2;
    localparam logic [CNT_W-1:0] LAST_CNT = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic              ovf;

    logic [MAG_W-1:0]  mag_c;
    logic [ACC_W-1:0]  mag_ext_c;
    logic [ACC_W-1:0]  x_c;
    logic [ACC_W:0]    sum_c;
    logic [ACC_W-1:0]  sat_c;
    logic              add_ovf_c;
    logic              accept_c;
    logic              last_c;
    logic [ACC_W-1:0]  result_c;

    // Float expansion: v << e, negated for s=1 (negative zero naturally gives 0)
    assign mag_c     = {7'd0, in_fp[3:0]} << in_fp[6:4];
    assign mag_ext_c = {{(ACC_W-MAG_W){1'b0}}, mag_c};
    assign x_c       = in_fp[7] ? (ACC_W'(0) - mag_ext_c) : mag_ext_c;

    // Saturating add at ACC_W+1 bits; top two bits differing means overflow
    always_comb begin
        sum_c     = {acc[ACC_W-1], acc} + {x_c[ACC_W-1], x_c};
        sat_c     = sum_c[ACC_W-1:0];
        add_ovf_c = 1'b0;
        if (sum_c[ACC_W] != sum_c[ACC_W-1]) begin
            add_ovf_c = 1'b1;
            sat_c     = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

`ifdef FP_BLOCK_ACCUM_MEAN_EN
    // Rounded mean: add half an LSB of the result, then arithmetic shift
    localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (N_LOG2 - 1);
    logic signed [ACC_W:0] rnd_c;
    logic signed [ACC_W:0] mean_c;
    assign rnd_c    = $signed({sat_c[ACC_W-1], sat_c} + HALF);
    assign mean_c   = rnd_c >>> N_LOG2;
    assign result_c = mean_c[ACC_W-1:0];
`else
    assign result_c = sat_c;
`endif

    // Handshake qualifiers; clear drops the sample presented with it
    assign accept_c = in_valid & in_ready & ~clear;
    assign last_c   = accept_c & (count == LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (last_c)    state_nxt = HOLD;
                HOLD:    if (out_ready) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM:   in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b1;
        endcase
    end

    // Accumulator, sample counter, overflow flag and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept_c) begin
            if (last_c) begin
                out_sum <= result_c;
                out_ovf <= ovf | add_ovf_c;
                acc     <= '0;
                count   <= '0;
                ovf     <= 1'b0;
            end else begin
                acc   <= sat_c;
                count <= count + CNT_W'(1);
                ovf   <= ovf | add_ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_fp_block_accum.sv
// Directed testbench for fp_block_accum. Two instances share all inputs:
// a default ACC_W=16 unit and an ACC_W=12 unit used for the saturation cases.
module tb_fp_block_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_fp;
    logic        out_ready;

    logic        in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_sum16;
    logic        in_ready12, out_valid12, out_ovf12;
    logic [11:0] out_sum12;

    int tests = 0;
    int fails = 0;

`ifdef FP_BLOCK_ACCUM_MEAN_EN
    localparam int E_BASIC = 44;
    localparam int E_MIXED = 6;
    localparam int E_BP    = 128;
    localparam int E_SAT12 = 256;
    localparam int E_SAT16 = 1920;
    localparam int E_SMALL = 15;
`else
    localparam int E_BASIC = 352;
    localparam int E_MIXED = 44;
    localparam int E_BP    = 1024;
    localparam int E_SAT12 = 2047;
    localparam int E_SAT16 = 15360;
    localparam int E_SMALL = 120;
`endif

    always #5 clk = ~clk;

    fp_block_accum #(.ACC_W(16), .N_LOG2(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready16), .in_fp(in_fp),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_sum(out_sum16), .out_ovf(out_ovf16)
    );

    fp_block_accum #(.ACC_W(12), .N_LOG2(3)) dut12 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready12), .in_fp(in_fp),
        .out_valid(out_valid12), .out_ready(out_ready),
        .out_sum(out_sum12), .out_ovf(out_ovf12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n samples with in_valid high; in_ready must be 1 before each edge
    task automatic push(input logic [7:0] code, input int n, input string tag);
        in_valid = 1'b1;
        in_fp    = code;
        for (int i = 0; i < n; i++) begin
            tests++;
            if (in_ready16 !== 1'b1) begin
                fails++;
                $display("FAIL %s_in_ready[%0d]: got %b want 1", tag, i, in_ready16);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Accept the pending result and check the handshake returns to ACCUM
    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            fails++;
            $display("FAIL %s_drain: got valid=%b ready=%b want valid=0 ready=1",
                     tag, out_valid16, in_ready16);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_fp = 8'h00; out_ready = 1'b0;
        repeat (2) tick();
        tests++;
        if (out_valid16 !== 1'b0 || out_sum16 !== 16'd0 || out_ovf16 !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b sum=%0d ovf=%b want 0/0/0",
                     out_valid16, out_sum16, out_ovf16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready16 !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready16);
        end
    endtask

    task automatic test_basic();
        push(8'h2B, 7, "basic");
        tests++;
        if (out_valid16 !== 1'b0) begin
            fails++;
            $display("FAIL basic_early_valid: got %b want 0", out_valid16);
        end
        push(8'h2B, 1, "basic_last");
        tests++;
        if (out_valid16 !== 1'b1 || out_sum16 !== 16'(E_BASIC) || out_ovf16 !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: got valid=%b sum=%0d ovf=%b want 1/%0d/0",
                     out_valid16, out_sum16, out_ovf16, E_BASIC);
        end
        drain("basic");
    endtask

    task automatic test_mixed_sign();
        push(8'h2B, 4, "mixed_pos");
        push(8'hAB, 3, "mixed_neg");
        push(8'h80, 1, "mixed_nzero");
        tests++;
        if (out_valid16 !== 1'b1 || out_sum16 !== 16'(E_MIXED) || out_ovf16 !== 1'b0) begin
            fails++;
            $display("FAIL mixed_result: got valid=%b sum=%0d ovf=%b want 1/%0d/0",
                     out_valid16, out_sum16, out_ovf16, E_MIXED);
        end
        drain("mixed");
    endtask

    task automatic test_backpressure();
        push(8'h71, 8, "bp");
        // Large codes offered during HOLD must be ignored
        in_valid = 1'b1;
        in_fp    = 8'h7F;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (in_ready16 !== 1'b0 || out_valid16 !== 1'b1 || out_sum16 !== 16'(E_BP)) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got ready=%b valid=%b sum=%0d want 0/1/%0d",
                         i, in_ready16, out_valid16, out_sum16, E_BP);
            end
            tick();
        end
        drain("bp");
        in_valid = 1'b0;
        push(8'h2B, 8, "bp_next");
        tests++;
        if (out_valid16 !== 1'b1 || out_sum16 !== 16'(E_BASIC)) begin
            fails++;
            $display("FAIL bp_next_result: got valid=%b sum=%0d want 1/%0d",
                     out_valid16, out_sum16, E_BASIC);
        end
        drain("bp_next");
    endtask

    task automatic test_clear();
        push(8'h7F, 3, "clr_pre");
        clear = 1'b1; in_valid = 1'b1; in_fp = 8'h7F;
        tests++;
        if (in_ready16 !== 1'b1) begin
            fails++;
            $display("FAIL clear_in_ready: got %b want 1", in_ready16);
        end
        tick();
        clear = 1'b0; in_valid = 1'b0;
        push(8'h10, 8, "clr_zero");
        tests++;
        if (out_valid16 !== 1'b1 || out_sum16 !== 16'd0 || out_ovf12 !== 1'b0) begin
            fails++;
            $display("FAIL clear_result: got valid=%b sum=%0d ovf12=%b want 1/0/0",
                     out_valid16, out_sum16, out_ovf12);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests++;
        if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
            fails++;
            $display("FAIL clear_hold: got valid=%b ready=%b want 0/1",
                     out_valid16, in_ready16);
        end
    endtask

    task automatic test_saturation();
        push(8'h7F, 8, "sat");
        tests++;
        if (out_valid12 !== 1'b1 || out_sum12 !== 12'(E_SAT12) || out_ovf12 !== 1'b1) begin
            fails++;
            $display("FAIL sat12_result: got valid=%b sum=%0d ovf=%b want 1/%0d/1",
                     out_valid12, out_sum12, out_ovf12, E_SAT12);
        end
        tests++;
        if (out_sum16 !== 16'(E_SAT16) || out_ovf16 !== 1'b0) begin
            fails++;
            $display("FAIL sat16_result: got sum=%0d ovf=%b want %0d/0",
                     out_sum16, out_ovf16, E_SAT16);
        end
        drain("sat");
        push(8'h0F, 8, "sat_next");
        tests++;
        if (out_valid12 !== 1'b1 || out_sum12 !== 12'(E_SMALL) || out_ovf12 !== 1'b0) begin
            fails++;
            $display("FAIL sat12_next: got valid=%b sum=%0d ovf=%b want 1/%0d/0",
                     out_valid12, out_sum12, out_ovf12, E_SMALL);
        end
        drain("sat_next");
    endtask

    task automatic test_reset_mid();
        // Reset while a result is pending
        push(8'h2B, 8, "rst_hold");
        tests++;
        if (out_valid16 !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_valid: got %b want 1", out_valid16);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid16 !== 1'b0 || out_sum16 !== 16'd0 || out_ovf16 !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: got valid=%b sum=%0d ovf=%b want 0/0/0",
                     out_valid16, out_sum16, out_ovf16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
            fails++;
            $display("FAIL rst_release: got ready=%b valid=%b want 1/0",
                     in_ready16, out_valid16);
        end
        // Reset during a partial block must discard the partial sum and count
        push(8'h7F, 3, "rst_part");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push(8'h2B, 8, "rst_after");
        tests++;
        if (out_valid16 !== 1'b1 || out_sum16 !== 16'(E_BASIC) || out_ovf12 !== 1'b0) begin
            fails++;
            $display("FAIL rst_after_result: got valid=%b sum=%0d ovf12=%b want 1/%0d/0",
                     out_valid16, out_sum16, out_ovf12, E_BASIC);
        end
        drain("rst_after");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mixed_sign();
        test_backpressure();
        test_clear();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
